johnson_ring_counter: RTL and testbench

JOHNSON_RING_COUNTER -- requirements
Module: johnson_ring_counter

---
 rtl/johnson_ring_counter.sv | 118 +++++++++++
 tb/tb_johnson_ring_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/johnson_ring_counter.sv
// Bidirectional Johnson / one-hot ring counter with runtime mode switch,
// synchronous load, self-correction of illegal states and a decoded phase.
module johnson_ring_counter #(
  parameter  int N  = 9,
  localparam int PW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rset_n,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  count_out,
  output logic [PW-1:0] phase,
  output logic          tc,
  output logic          err
);

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  localparam logic [N-1:0] RING_SEED = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0]  q, q_next, q_step;
  mode_e         mode_q, mode_q_next, mode_in;
  logic          err_next;
  logic [PW-1:0] ones, trans, idx;
  logic [PW-1:0] phase_legal, last_phase;
  logic          legal;

  function automatic logic [N-1:0] seed(input mode_e m);
    return (m == MODE_RING) ? RING_SEED : '0;
  endfunction

  assign mode_in = mode_e'(mode);

  // Population count, count of adjacent-bit transitions and set-bit index.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    ones  = '0;
    trans = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + PW'(q[i]);
      if (q[i]) idx = PW'(i);
    end
    for (int i = 0; i < N - 1; i++) begin
      trans = trans + PW'(q[i] ^ q[i+1]);
    end
  end

  assign legal = (mode_q == MODE_RING) ? (ones == PW'(1)) : (trans <= PW'(1));

  // Johnson states with the MSB clear (other than all-zero) sit in the
  // second half of the cycle, so their index counts back from 2N.
  always_comb begin
    phase_legal = '0;
    last_phase  = PW'(2 * N - 1);
    if (mode_q == MODE_RING) begin
      phase_legal = PW'(N - 1) - idx;
      last_phase  = PW'(N - 1);
    end else if (q[N-1] || (q == '0)) begin
      phase_legal = ones;
    end else begin
      phase_legal = PW'(2 * N) - ones;
    end
  end

  assign phase     = legal ? phase_legal : '0;
  assign count_out = q;
  assign tc        = en && !load && (mode_in == mode_q) && legal &&
                     (dir ? (phase == '0) : (phase == last_phase));

  always_comb begin
    q_step = q;
    if (mode_q == MODE_RING) begin
      q_step = dir ? {q[N-2:0], q[N-1]} : {q[0], q[N-1:1]};
    end else begin
      q_step = dir ? {q[N-2:0], ~q[N-1]} : {~q[0], q[N-1:1]};
    end
  end

  // Correction outranks a mode change so the reseed always uses the mode
  // the illegal state was judged against; the new mode follows next edge.
  always_comb begin
    q_next      = q;
    mode_q_next = mode_q;
    err_next    = 1'b0;
    if (!legal) begin
      q_next   = seed(mode_q);
      err_next = 1'b1;
    end else if (mode_in != mode_q) begin
      q_next      = seed(mode_in);
      mode_q_next = mode_in;
    end else if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next = q_step;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) begin
      q      <= '0;
      mode_q <= MODE_JOHNSON;
      err    <= 1'b0;
    end else begin
      q      <= q_next;
      mode_q <= mode_q_next;
      err    <= err_next;
    end
  end

endmodule

// File: tb/tb_johnson_ring_counter.sv
// Directed bench for johnson_ring_counter: an N=3 and an N=4 instance share
// control inputs; each step checks against hand-computed values.
module tb_johnson_ring_counter;

  localparam int N3  = 3;
  localparam int N4  = 4;
  localparam int PW3 = $clog2(2 * N3);
  localparam int PW4 = $clog2(2 * N4);

  logic           clk = 1'b0;
  logic           rset_n, en, dir, mode, load;
  logic [N3-1:0]  load_val3, count3;
  logic [N4-1:0]  load_val4, count4;
  logic [PW3-1:0] phase3;
  logic [PW4-1:0] phase4;
  logic           tc3, tc4, err3, err4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  johnson_ring_counter #(.N(N3)) dut3 (
    .clk(clk), .rset_n(rset_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val3), .count_out(count3), .phase(phase3), .tc(tc3), .err(err3)
  );

  johnson_ring_counter #(.N(N4)) dut4 (
    .clk(clk), .rset_n(rset_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val4), .count_out(count4), .phase(phase4), .tc(tc4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N3-1:0] j3_cnt [7];
    int            j3_ph  [7];
    logic          j3_tc  [7];
    logic [N4-1:0] r4_cnt [4];
    int            r4_ph  [4];
    logic          r4_tc  [4];

    j3_cnt = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    j3_ph  = '{0, 1, 2, 3, 4, 5, 0};
    j3_tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    r4_cnt = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    r4_ph  = '{1, 2, 3, 0};
    r4_tc  = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state and tc behaviour while held in reset
    rset_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
    load_val3 = '0; load_val4 = '0;
    #12;
    check("rst_count", count4, 4'b0000);
    check("rst_phase", phase4, 0);
    check("rst_err", err4, 1'b0);
    check("rst_tc_en0", tc4, 1'b0);
    en = 1'b1; dir = 1'b1; #1;
    check("rst_tc_down", tc4, 1'b1);
    dir = 1'b0; #1;
    check("rst_tc_up", tc4, 1'b0);

    // N=3 Johnson count up through a full cycle
    tick();
    rset_n = 1'b1; #1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      check($sformatf("j3_count[%0d]", i), count3, j3_cnt[i]);
      check($sformatf("j3_phase[%0d]", i), phase3, j3_ph[i]);
      check($sformatf("j3_tc[%0d]", i), tc3, j3_tc[i]);
    end

    // N=4 ring from reset: first edge reseeds without err
    rset_n = 1'b0; mode = 1'b1; en = 1'b1; dir = 1'b0; #1;
    rset_n = 1'b1; #1;
    check("r4_tc_pre_seed", tc4, 1'b0);
    tick();
    check("r4_seed_count", count4, 4'b1000);
    check("r4_seed_err", err4, 1'b0);
    check("r4_seed_phase", phase4, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("r4_count[%0d]", i), count4, r4_cnt[i]);
      check($sformatf("r4_phase[%0d]", i), phase4, r4_ph[i]);
      check($sformatf("r4_tc[%0d]", i), tc4, r4_tc[i]);
    end

    // Load and mode toggle on the same edge: reseed wins
    load = 1'b1; load_val4 = 4'b0011; mode = 1'b0;
    tick();
    load = 1'b0; en = 1'b0;
    check("reseed_over_load", count4, 4'b0000);
    check("reseed_err", err4, 1'b0);

    // Illegal load is shown for one cycle, then corrected with err pulse
    load = 1'b1; load_val4 = 4'b0101;
    tick();
    load = 1'b0;
    check("ill_load_count", count4, 4'b0101);
    check("ill_load_phase", phase4, 0);
    check("ill_load_err", err4, 1'b0);
    tick();
    check("ill_fix_count", count4, 4'b0000);
    check("ill_fix_err", err4, 1'b1);
    tick();
    check("ill_err_clear", err4, 1'b0);

    // Johnson count down from 1100 with wrap, then up-wrap and hold
    load = 1'b1; load_val4 = 4'b1100;
    tick();
    load = 1'b0;
    check("jd_load_count", count4, 4'b1100);
    check("jd_load_phase", phase4, 2);
    dir = 1'b1; en = 1'b1; #1;
    check("jd_tc_mid", tc4, 1'b0);
    tick();
    check("jd_count_1000", count4, 4'b1000);
    check("jd_phase_1", phase4, 1);
    tick();
    check("jd_count_0000", count4, 4'b0000);
    check("jd_tc_at_0", tc4, 1'b1);
    tick();
    check("jd_count_0001", count4, 4'b0001);
    check("jd_phase_7", phase4, 7);
    dir = 1'b0; #1;
    check("ju_tc_at_7", tc4, 1'b1);
    en = 1'b0; #1;
    check("ju_tc_en0", tc4, 1'b0);
    tick();
    check("hold_count", count4, 4'b0001);
    en = 1'b1;
    tick();
    check("ju_wrap_count", count4, 4'b0000);
    check("ju_wrap_phase", phase4, 0);

    // Mode change during an illegal state waits for the correction edge
    en = 1'b0; load = 1'b1; load_val4 = 4'b0101;
    tick();
    load = 1'b0; mode = 1'b1;
    tick();
    check("ill_mode_count", count4, 4'b0000);
    check("ill_mode_err", err4, 1'b1);
    tick();
    check("ill_mode_reseed", count4, 4'b1000);
    check("ill_mode_err_clr", err4, 1'b0);

    // Asynchronous reset mid-cycle from ring state 0010
    en = 1'b1; dir = 1'b0;
    tick();
    tick();
    check("ar_pre_count", count4, 4'b0010);
    #2;
    rset_n = 1'b0; #1;
    check("ar_count", count4, 4'b0000);
    check("ar_phase", phase4, 0);
    check("ar_err", err4, 1'b0);
    rset_n = 1'b1;
    tick();
    check("ar_reseed_count", count4, 4'b1000);
    check("ar_reseed_err", err4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
